// File: rtl/cnn_pkg.sv
// Shared CNN accelerator defaults and the weight scheduler FSM encoding.
package cnn_pkg;

    // Array geometry and memory defaults shared across the accelerator.
    localparam int unsigned MATRIX_A_ROW        = 8;
    localparam int unsigned INT_WIDTH           = 8;
    localparam int unsigned ROM_WEIGHTS_DEPTH_W = 10;

    // Weight scheduler FSM; plain constants keep the encoding legacy-compatible.
    typedef logic [1:0] wsch_state_e;
    localparam wsch_state_e IDLE   = 2'd0;
    localparam wsch_state_e ARMED  = 2'd1;
    localparam wsch_state_e STREAM = 2'd2;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register with hold (en) and synchronous flush (clr).
// clr wins over en so a flush is never blocked by a stall.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_async_n_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    // Shift one stage per enabled cycle; flush clears every stage.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/weight_stream_scheduler.sv
// West-side weight feeder: streams K*K*C weights per window from weight ROM,
// aligns them to the ROM latency and skews them one extra cycle per row.
module weight_stream_scheduler
    import cnn_pkg::*;
#(
    parameter int unsigned ROWS    = MATRIX_A_ROW,
    parameter int unsigned DATA_W  = INT_WIDTH,
    parameter int unsigned ADDR_W  = ROM_WEIGHTS_DEPTH_W,
    parameter int unsigned KR_W    = 4,
    parameter int unsigned CH_W    = 4,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_async_n_i,
    input  logic                   enable_i,
    input  logic                   sync_i,
    input  logic                   stall_i,
    input  logic [KR_W-1:0]        cfg_kernel_r_i,
    input  logic [CH_W-1:0]        cfg_in_ch_i,
    input  logic [ADDR_W-1:0]      cfg_base_addr_i,
    output logic                   rom_rd_en_o,
    output logic [ADDR_W-1:0]      rom_addr_o,
    input  logic [ROWS*DATA_W-1:0] rom_data_i,
    output logic [ROWS-1:0]        west_valid_o,
    output logic [ROWS*DATA_W-1:0] west_data_o,
    output logic                   window_done_o,
    output logic                   busy_o,
    output logic                   cfg_err_o
);

    localparam int unsigned LenW = 2 * KR_W + CH_W;
    localparam int unsigned SumW = ((ADDR_W > LenW) ? ADDR_W : LenW) + 1;

    wsch_state_e       state_q, state_d;
    logic [LenW-1:0]   idx_q, idx_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              cfg_err_q, cfg_err_d;

    logic [KR_W-1:0]   k_eff;
    logic [CH_W-1:0]   c_eff;
    logic [LenW-1:0]   len_new;
    logic [SumW-1:0]   end_addr;
    logic              cfg_bad;

    logic              active;
    logic              issue;
    logic              last;
    logic              v0;
    logic              last0;

    // Config sanitising: zero K or C behaves as 1 but is flagged.
    always_comb begin
        k_eff    = (cfg_kernel_r_i == '0) ? KR_W'(1) : cfg_kernel_r_i;
        c_eff    = (cfg_in_ch_i == '0) ? CH_W'(1) : cfg_in_ch_i;
        len_new  = LenW'(k_eff) * LenW'(k_eff) * LenW'(c_eff);
        end_addr = SumW'(cfg_base_addr_i) + SumW'(len_new) - SumW'(1);
        cfg_bad  = (cfg_kernel_r_i == '0) || (cfg_in_ch_i == '0) ||
                   (end_addr > SumW'({ADDR_W{1'b1}}));
    end

    assign active = (state_q == ARMED) || (state_q == STREAM);
    assign issue  = enable_i & ~stall_i & active & sync_i;
    assign last   = (idx_q == len_q - LenW'(1));

    // FSM, index counter and config latch; enable_i low overrides stall_i.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        base_d    = base_q;
        cfg_err_d = cfg_err_q;
        if (!enable_i) begin
            state_d = IDLE;
            idx_d   = '0;
            if (state_q == IDLE) cfg_err_d = 1'b0;
        end else if (!stall_i) begin
            case (state_q)
                IDLE: begin
                    state_d   = ARMED;
                    len_d     = len_new;
                    base_d    = cfg_base_addr_i;
                    cfg_err_d = cfg_bad;
                end
                ARMED:   if (sync_i) state_d = STREAM;
                STREAM:  if (!sync_i) state_d = ARMED;
                default: state_d = IDLE;
            endcase
            // Any non-issuing cycle parks idx at 0 so w0 is always pre-read.
            idx_d = issue ? (last ? '0 : idx_q + LenW'(1)) : '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            base_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            base_q    <= base_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign rom_rd_en_o = busy_o & ~stall_i;
    assign rom_addr_o  = base_q + ADDR_W'(idx_q);
    assign cfg_err_o   = cfg_err_q;

    // Issue and last-weight flags travel alongside the ROM read latency.
    skew_delay_line #(
        .DEPTH (ROM_LAT),
        .W     (2)
    ) u_align (
        .clk_i         (clk_i),
        .rst_async_n_i (rst_async_n_i),
        .en_i          (~stall_i),
        .clr_i         (~enable_i),
        .d_i           ({issue, issue & last}),
        .q_o           ({v0, last0})
    );

    assign west_valid_o[0]        = v0;
    assign west_data_o[DATA_W-1:0] = v0 ? rom_data_i[DATA_W-1:0] : '0;
    assign window_done_o          = v0 & last0;

    // Row r adds r cycles of skew on top of the latency-aligned lane r.
    for (genvar r = 1; r < ROWS; r++) begin : g_skew
        logic [DATA_W:0] skew_q;

        skew_delay_line #(
            .DEPTH (r),
            .W     (DATA_W + 1)
        ) u_skew (
            .clk_i         (clk_i),
            .rst_async_n_i (rst_async_n_i),
            .en_i          (~stall_i),
            .clr_i         (~enable_i),
            .d_i           ({v0, v0 ? rom_data_i[r*DATA_W +: DATA_W] : {DATA_W{1'b0}}}),
            .q_o           (skew_q)
        );

        assign west_valid_o[r]                = skew_q[DATA_W];
        assign west_data_o[r*DATA_W +: DATA_W] = skew_q[DATA_W-1:0];
    end

endmodule

// File: tb/tb_weight_stream_scheduler.sv
// Scoreboard bench for weight_stream_scheduler with a latency-accurate ROM model.
module tb_weight_stream_scheduler;

    localparam int unsigned ROWS    = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned KR_W    = 4;
    localparam int unsigned CH_W    = 4;
    localparam int unsigned ROM_LAT = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_async_n_i;
    logic                   enable_i;
    logic                   sync_i;
    logic                   stall_i;
    logic [KR_W-1:0]        cfg_kernel_r_i;
    logic [CH_W-1:0]        cfg_in_ch_i;
    logic [ADDR_W-1:0]      cfg_base_addr_i;
    logic                   rom_rd_en_o;
    logic [ADDR_W-1:0]      rom_addr_o;
    logic [ROWS*DATA_W-1:0] rom_data_i;
    logic [ROWS-1:0]        west_valid_o;
    logic [ROWS*DATA_W-1:0] west_data_o;
    logic                   window_done_o;
    logic                   busy_o;
    logic                   cfg_err_o;

    always #5 clk_i = ~clk_i;

    weight_stream_scheduler #(
        .ROWS    (ROWS),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .KR_W    (KR_W),
        .CH_W    (CH_W),
        .ROM_LAT (ROM_LAT)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_async_n_i   (rst_async_n_i),
        .enable_i        (enable_i),
        .sync_i          (sync_i),
        .stall_i         (stall_i),
        .cfg_kernel_r_i  (cfg_kernel_r_i),
        .cfg_in_ch_i     (cfg_in_ch_i),
        .cfg_base_addr_i (cfg_base_addr_i),
        .rom_rd_en_o     (rom_rd_en_o),
        .rom_addr_o      (rom_addr_o),
        .rom_data_i      (rom_data_i),
        .west_valid_o    (west_valid_o),
        .west_data_o     (west_data_o),
        .window_done_o   (window_done_o),
        .busy_o          (busy_o),
        .cfg_err_o       (cfg_err_o)
    );

    // Distinct content per address and lane.
    function automatic logic [ROWS*DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [ROWS*DATA_W-1:0] w;
        for (int r = 0; r < ROWS; r++) w[r*DATA_W +: DATA_W] = DATA_W'(32'(a) * 7 + r * 29 + 3);
        return w;
    endfunction

    // ROM pipeline only advances on a read strobe, so it holds data across stalls.
    logic [ROWS*DATA_W-1:0] rom_pipe [ROM_LAT];
    initial for (int i = 0; i < ROM_LAT; i++) rom_pipe[i] = '0;
    always @(posedge clk_i) begin
        if (rom_rd_en_o) begin
            rom_pipe[0] <= rom_word(rom_addr_o);
            for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
        end
    end
    assign rom_data_i = rom_pipe[ROM_LAT-1];

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [31:0]       due;
    } sb_item_t;

    sb_item_t sb_q [ROWS][$];

    int          n_checks;
    int          n_errors;
    int unsigned m_state;  // 0 idle, 1 armed, 2 stream
    int unsigned m_idx;
    int unsigned m_len;
    int unsigned m_base;
    logic        m_err;
    int unsigned tick;
    logic        prev_rep;
    logic [ROWS-1:0]        prev_valid;
    logic [ROWS*DATA_W-1:0] prev_data;
    logic                   prev_done;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_cfg(input int unsigned k, input int unsigned c, input int unsigned base);
        cfg_kernel_r_i  = KR_W'(k);
        cfg_in_ch_i     = CH_W'(c);
        cfg_base_addr_i = ADDR_W'(base);
    endtask

    task automatic run_cycle(input logic en, input logic sy, input logic st);
        logic                   exp_v;
        logic                   issue;
        logic                   lst;
        sb_item_t               it;
        logic [ADDR_W-1:0]      addr;
        logic [ROWS*DATA_W-1:0] w;
        int unsigned            k;
        int unsigned            c;
        @(posedge clk_i);
        #1;
        enable_i = en;
        sync_i   = sy;
        stall_i  = st;
        @(negedge clk_i);
        if (prev_rep) begin
            check_val("west_valid_frozen", 64'(west_valid_o), 64'(prev_valid));
            check_val("west_data_frozen", west_data_o, prev_data);
            check_val("done_frozen", 64'(window_done_o), 64'(prev_done));
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                exp_v = (sb_q[r].size() != 0) && (sb_q[r][0].due == tick);
                check_val($sformatf("west_valid[%0d]", r), 64'(west_valid_o[r]), 64'(exp_v));
                if (exp_v) begin
                    it = sb_q[r].pop_front();
                    check_val($sformatf("west_data[%0d]", r),
                              64'(west_data_o[r*DATA_W +: DATA_W]), 64'(it.data));
                    if (r == 0) check_val("window_done", 64'(window_done_o), 64'(it.last));
                end else begin
                    check_val($sformatf("west_data_zero[%0d]", r),
                              64'(west_data_o[r*DATA_W +: DATA_W]), 64'(0));
                    if (r == 0) check_val("window_done_idle", 64'(window_done_o), 64'(0));
                end
            end
        end
        prev_valid = west_valid_o;
        prev_data  = west_data_o;
        prev_done  = window_done_o;

        check_val("busy", 64'(busy_o), 64'(m_state != 0));
        check_val("rom_rd_en", 64'(rom_rd_en_o), 64'((m_state != 0) && !st));
        check_val("cfg_err", 64'(cfg_err_o), 64'(m_err));
        if (m_state != 0) begin
            check_val("rom_addr", 64'(rom_addr_o), 64'((m_base + m_idx) % (1 << ADDR_W)));
        end

        issue = en && !st && sy && (m_state != 0);
        lst   = (m_idx == m_len - 1);
        if (issue) begin
            addr = ADDR_W'(m_base + m_idx);
            w    = rom_word(addr);
            for (int r = 0; r < ROWS; r++) begin
                it.data = w[r*DATA_W +: DATA_W];
                it.last = lst;
                it.due  = 32'(tick + ROM_LAT + r);
                sb_q[r].push_back(it);
            end
        end

        if (!en) begin
            if (m_state == 0) m_err = 1'b0;
            m_state = 0;
            m_idx   = 0;
            for (int r = 0; r < ROWS; r++) sb_q[r].delete();
        end else if (!st) begin
            if (m_state == 0) begin
                k       = (cfg_kernel_r_i == 0) ? 1 : 32'(cfg_kernel_r_i);
                c       = (cfg_in_ch_i == 0) ? 1 : 32'(cfg_in_ch_i);
                m_len   = k * k * c;
                m_base  = 32'(cfg_base_addr_i);
                m_err   = (cfg_kernel_r_i == 0) || (cfg_in_ch_i == 0) ||
                          (m_base + m_len - 1 > (1 << ADDR_W) - 1);
                m_state = 1;
            end else if (m_state == 1) begin
                if (sy) m_state = 2;
            end else begin
                if (!sy) m_state = 1;
            end
            m_idx = issue ? (lst ? 0 : m_idx + 1) : 0;
        end
        prev_rep = en && st;
        if (!(en && st)) tick++;
    endtask

    task automatic run_n(input int n, input logic en, input logic sy, input logic st);
        for (int i = 0; i < n; i++) run_cycle(en, sy, st);
    endtask

    // Let in-flight weights leave the skew, confirm nothing was lost, then idle.
    task automatic drain_check();
        run_n(ROWS + ROM_LAT + 2, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            check_val($sformatf("sb_drain[%0d]", r), 64'(sb_q[r].size()), 64'(0));
        end
        run_n(2, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        m_state       = 0;
        m_idx         = 0;
        m_len         = 1;
        m_base        = 0;
        m_err         = 1'b0;
        tick          = 0;
        prev_rep      = 1'b0;
        prev_valid    = '0;
        prev_data     = '0;
        prev_done     = 1'b0;
        rst_async_n_i = 1'b0;
        enable_i      = 1'b0;
        sync_i        = 1'b0;
        stall_i       = 1'b0;
        set_cfg(0, 0, 0);

        repeat (3) @(negedge clk_i);
        check_val("rst_rd_en", 64'(rom_rd_en_o), 64'(0));
        check_val("rst_addr", 64'(rom_addr_o), 64'(0));
        check_val("rst_valid", 64'(west_valid_o), 64'(0));
        check_val("rst_data", west_data_o, 64'(0));
        check_val("rst_done", 64'(window_done_o), 64'(0));
        check_val("rst_busy", 64'(busy_o), 64'(0));
        check_val("rst_cfg_err", 64'(cfg_err_o), 64'(0));
        rst_async_n_i = 1'b1;

        // K=3 C=1: one 9-weight window.
        set_cfg(3, 1, 'h020);
        run_n(2, 1'b1, 1'b0, 1'b0);
        run_n(9, 1'b1, 1'b1, 1'b0);
        drain_check();

        // K=2 C=2: sync gap mid-window restarts at base.
        set_cfg(2, 2, 'h100);
        run_n(2, 1'b1, 1'b0, 1'b0);
        run_n(6, 1'b1, 1'b1, 1'b0);
        run_n(3, 1'b1, 1'b0, 1'b0);
        run_n(6, 1'b1, 1'b1, 1'b0);
        drain_check();

        // Three-cycle stall mid-window.
        set_cfg(3, 1, 'h040);
        run_n(2, 1'b1, 1'b0, 1'b0);
        run_n(4, 1'b1, 1'b1, 1'b0);
        run_n(3, 1'b1, 1'b1, 1'b1);
        run_n(5, 1'b1, 1'b1, 1'b0);
        drain_check();

        // enable_i drops at idx=4 together with stall_i, then re-enable.
        set_cfg(3, 1, 'h060);
        run_n(2, 1'b1, 1'b0, 1'b0);
        run_n(4, 1'b1, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b1);
        run_n(1, 1'b0, 1'b0, 1'b0);
        run_n(2, 1'b1, 1'b0, 1'b0);
        run_n(9, 1'b1, 1'b1, 1'b0);
        drain_check();

        // K=0 C=3: flagged, streams LEN=3; error held until back in IDLE.
        set_cfg(0, 3, 'h200);
        run_n(2, 1'b1, 1'b0, 1'b0);
        run_n(7, 1'b1, 1'b1, 1'b0);
        drain_check();
        run_n(1, 1'b0, 1'b0, 1'b0);

        // Range overflow wraps addresses.
        set_cfg(2, 1, 'h3FE);
        run_n(2, 1'b1, 1'b0, 1'b0);
        run_n(4, 1'b1, 1'b1, 1'b0);
        drain_check();

        // LEN=1 with a stall while armed and sync high.
        set_cfg(1, 1, 'h155);
        run_n(2, 1'b1, 1'b0, 1'b0);
        run_n(2, 1'b1, 1'b1, 1'b1);
        run_n(4, 1'b1, 1'b1, 1'b0);
        drain_check();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
